// File: rtl/s_axis_rq_pkt_fifo_x16_pkg.sv
// Shared constants, tuser bit positions and input FSM encoding for the RQ packet FIFO.
package rq_pkt_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DFLT = 512;
    localparam int unsigned KEEP_WIDTH_DFLT = 16;
    localparam int unsigned ELEM_W          = DATA_WIDTH_DFLT + KEEP_WIDTH_DFLT + 5;

    localparam int unsigned TUSER_ECRC   = 0;
    localparam int unsigned TUSER_POISON = 1;
    localparam int unsigned TUSER_DISC   = 3;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } in_state_e;

    // Stored element is {tuser[3:0], tlast, tkeep, tdata}
    function automatic int unsigned elem_width(input int unsigned dw, input int unsigned kw);
        return dw + kw + 5;
    endfunction

endpackage

// File: rtl/s_axis_rq_pkt_fifo_x16_if.sv
// AXI4-Stream request bus bundle used on both sides of the RQ packet FIFO.
interface s_axis_rq_pkt_fifo_x16_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [3:0]            tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/s_axis_rq_pkt_fifo_x16_ram.sv
// Simple dual-port RAM with registered, enable-gated read port (rdata holds when re is low).
module rq_pkt_fifo_ram #(
    parameter int unsigned WIDTH  = 533,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/s_axis_rq_pkt_fifo_x16.sv
// Store-and-forward TLP FIFO: releases a TLP only after its tlast beat is stored;
// discontinued and oversize TLPs are discarded whole.
module s_axis_rq_pkt_fifo_x16
    import rq_pkt_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 512,
    parameter  int unsigned KEEP_WIDTH = 16,
    parameter  int unsigned DEPTH      = 64,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                            user_clk,
    input  logic                            user_reset,
    s_axis_rq_pkt_fifo_x16_if.slave         s_axis,
    s_axis_rq_pkt_fifo_x16_if.master        m_axis,
    output logic [ADDR_W:0]                 pkt_count,
    output logic                            drop_pulse,
    output logic                            oversize
);
    localparam int unsigned ELEM_W = elem_width(DATA_WIDTH, KEEP_WIDTH);

    typedef logic [ADDR_W:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    in_state_e         state;
    ptr_t              wr_ptr, cmt_ptr, rd_ptr, fe_ptr, pkt_len;
    logic              disc;
    logic              full, s_hs, m_hs, beat_disc, commit, pkt_done;
    logic              ram_we, ram_re, ram_vld, out_ld, out_vld;
    logic [ELEM_W-1:0] ram_rdata, out_q;

    // rd_ptr only advances on an output handshake, so prefetched beats still count as occupied
    assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
    assign s_axis.tready = !user_reset && ((state == ST_DROP) || !full);
    assign s_hs      = s_axis.tvalid && s_axis.tready;
    assign beat_disc = s_axis.tuser[TUSER_DISC];
    assign ram_we    = s_hs && (state == ST_ACCEPT);
    assign commit    = ram_we && s_axis.tlast && !disc && !beat_disc;

    assign m_axis.tvalid = out_vld;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_q;
    assign m_hs      = out_vld && m_axis.tready;
    assign pkt_done  = m_hs && m_axis.tlast;
    assign out_ld    = ram_vld && (!out_vld || m_axis.tready);
    assign ram_re    = (fe_ptr != cmt_ptr) && (!ram_vld || out_ld);

    rq_pkt_fifo_ram #(
        .WIDTH  (ELEM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (user_clk),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata ({s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
        .re    (ram_re),
        .raddr (fe_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state      <= ST_ACCEPT;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            pkt_len    <= '0;
            disc       <= 1'b0;
            drop_pulse <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (s_hs) begin
                        if (s_axis.tlast) begin
                            pkt_len <= '0;
                            disc    <= 1'b0;
                            if (commit) begin
                                wr_ptr  <= wr_ptr + 1'b1;
                                cmt_ptr <= wr_ptr + 1'b1;
                            end else begin
                                wr_ptr     <= cmt_ptr;
                                drop_pulse <= 1'b1;
                            end
                        end else if (pkt_len + 1'b1 == DEPTH_P) begin
                            state    <= ST_DROP;
                            wr_ptr   <= cmt_ptr;
                            oversize <= 1'b1;
                            pkt_len  <= '0;
                            disc     <= 1'b0;
                        end else begin
                            wr_ptr  <= wr_ptr + 1'b1;
                            pkt_len <= pkt_len + 1'b1;
                            disc    <= disc | beat_disc;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_hs && s_axis.tlast) begin
                        drop_pulse <= 1'b1;
                        state      <= ST_ACCEPT;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    // RAM read register and output register form a two-stage prefetch pipeline
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            fe_ptr  <= '0;
            rd_ptr  <= '0;
            ram_vld <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            if (ram_re) fe_ptr <= fe_ptr + 1'b1;
            if (ram_re) ram_vld <= 1'b1;
            else if (out_ld) ram_vld <= 1'b0;
            if (out_ld) out_vld <= 1'b1;
            else if (m_hs) out_vld <= 1'b0;
            if (m_hs) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (out_ld) out_q <= ram_rdata;
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            pkt_count <= '0;
        end else begin
            case ({commit, pkt_done})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_s_axis_rq_pkt_fifo_x16.sv
// Randomized bench for the RQ packet FIFO against a packet-level queue model.
module tb_s_axis_rq_pkt_fifo_x16;
    localparam int DEPTH = 16;
    localparam int EW    = 533;
    typedef logic [543:0] cw_t;

    logic       user_clk = 1'b0;
    logic       user_reset;
    logic [4:0] pkt_count;
    logic       drop_pulse, oversize;

    s_axis_rq_pkt_fifo_x16_if #(.DATA_WIDTH(512), .KEEP_WIDTH(16)) s_if ();
    s_axis_rq_pkt_fifo_x16_if #(.DATA_WIDTH(512), .KEEP_WIDTH(16)) m_if ();

    s_axis_rq_pkt_fifo_x16 #(.DATA_WIDTH(512), .KEEP_WIDTH(16), .DEPTH(DEPTH)) dut (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .pkt_count  (pkt_count),
        .drop_pulse (drop_pulse),
        .oversize   (oversize)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rmode = 0;
    int tlast_edge = -1;
    int rise_edge = -1;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur[$];
    bit            cur_disc, model_ovs, exp_drop;
    int            model_pkts;
    bit            prev_stall, prev_mid, prev_mv;
    logic [EW-1:0] prev_elem;

    task automatic chk(input string tag, input cw_t got, input cw_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge user_clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge user_clk);
        #1;
        case (rmode)
            0:       m_if.tready = 1'b0;
            1:       m_if.tready = 1'b1;
            default: m_if.tready = 1'($urandom_range(1, 0));
        endcase
    end

    // Reference model: whole packets are accepted or discarded by their length/discontinue
    initial forever begin
        logic [EW-1:0] m_elem, s_elem, e;
        bit            exp_tr;
        @(negedge user_clk);
        m_elem = {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
        s_elem = {s_if.tuser, s_if.tlast, s_if.tkeep, s_if.tdata};
        if (user_reset === 1'b1) begin
            chk("tready_in_reset", cw_t'(s_if.tready), cw_t'(0));
            exp_q.delete();
            cur.delete();
            cur_disc = 0; model_ovs = 0; exp_drop = 0; model_pkts = 0;
            prev_stall = 0; prev_mid = 0; prev_mv = 0;
        end else if (user_reset === 1'b0) begin
            exp_tr = (cur.size() >= DEPTH) || (exp_q.size() + cur.size() < DEPTH);
            chk("pkt_count", cw_t'(pkt_count), cw_t'(model_pkts));
            chk("drop_pulse", cw_t'(drop_pulse), cw_t'(exp_drop));
            chk("oversize", cw_t'(oversize), cw_t'(model_ovs));
            chk("s_tready", cw_t'(s_if.tready), cw_t'(exp_tr));
            exp_drop = 0;
            if (prev_stall) chk("m_hold", cw_t'({m_if.tvalid, m_elem}), cw_t'({1'b1, prev_elem}));
            if (prev_mid) chk("m_gap", cw_t'(m_if.tvalid), cw_t'(1));
            if (m_if.tvalid) chk("m_valid_has_data", cw_t'(exp_q.size() != 0), cw_t'(1));
            if (m_if.tvalid && !prev_mv) rise_edge = cyc;
            if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("m_beat", cw_t'(m_elem), cw_t'(e));
                if (m_if.tlast) model_pkts--;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_mid   = m_if.tvalid && m_if.tready && !m_if.tlast;
            prev_mv    = m_if.tvalid;
            prev_elem  = m_elem;
            if (s_if.tvalid && s_if.tready) begin
                cur.push_back(s_elem);
                cur_disc |= s_if.tuser[3];
                if (s_if.tlast) begin
                    tlast_edge = cyc + 1;
                    if (cur_disc || cur.size() > DEPTH) exp_drop = 1;
                    else begin
                        foreach (cur[i]) exp_q.push_back(cur[i]);
                        model_pkts++;
                    end
                    cur.delete();
                    cur_disc = 0;
                end else if (cur.size() == DEPTH) begin
                    model_ovs = 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input int disc_at, input bit give_last, input bit rnd_valid);
        for (int b = 0; b < len; b++) begin
            bit hs;
            int waitc;
            if (rnd_valid)
                for (int k = 0; k < 8 && $urandom_range(1, 0) == 0; k++) begin
                    s_if.tvalid = 1'b0;
                    step(1);
                end
            for (int w = 0; w < 16; w++) s_if.tdata[w*32 +: 32] = $urandom();
            s_if.tkeep  = 16'($urandom());
            s_if.tuser  = {(b == disc_at), 3'($urandom())};
            s_if.tlast  = give_last && (b == len - 1);
            s_if.tvalid = 1'b1;
            hs = 0;
            waitc = 0;
            while (!hs) begin
                @(negedge user_clk);
                hs = s_if.tready;
                step(1);
                waitc++;
                if (!hs && waitc > 5000) begin
                    chk("s_timeout", cw_t'(0), cw_t'(1));
                    s_if.tvalid = 1'b0;
                    return;
                end
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 20000) begin
            step(1);
            n++;
        end
        if (n >= 20000) chk("drain_timeout", cw_t'(0), cw_t'(1));
        step(2);
    endtask

    task automatic check_latency(input string tag);
        int n = 0;
        while (rise_edge < 0 && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, cw_t'(rise_edge - tlast_edge), cw_t'(2));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        user_reset  = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;
        step(3);
        user_reset = 1'b0;
        step(1);
        chk("rst_tvalid", cw_t'(m_if.tvalid), cw_t'(0));
        chk("rst_pkt_count", cw_t'(pkt_count), cw_t'(0));
        chk("rst_tready", cw_t'(s_if.tready), cw_t'(1));
        chk("rst_oversize", cw_t'(oversize), cw_t'(0));

        // single 3-beat TLP, latency from tlast to first valid
        rmode = 1;
        step(2);
        rise_edge = -1;
        send_pkt(3, -1, 1, 0);
        check_latency("latency_first");
        wait_drain();

        // discontinued TLP then a good one
        send_pkt(4, 1, 1, 0);
        step(4);
        chk("disc_no_output", cw_t'(m_if.tvalid), cw_t'(0));
        send_pkt(2, -1, 1, 0);
        wait_drain();

        // exactly DEPTH beats still passes
        send_pkt(DEPTH, -1, 1, 0);
        wait_drain();

        // oversize: 20 beats, tlast on beat 20
        send_pkt(20, -1, 1, 0);
        step(2);
        chk("oversize_set", cw_t'(oversize), cw_t'(1));
        send_pkt(3, -1, 1, 0);
        wait_drain();

        // fill with output stalled, then release
        rmode = 0;
        step(2);
        for (int p = 0; p < 4; p++) send_pkt(4, -1, 1, 0);
        step(3);
        chk("full_tready", cw_t'(s_if.tready), cw_t'(0));
        chk("full_pkt_count", cw_t'(pkt_count), cw_t'(4));
        rmode = 1;
        wait_drain();

        // random backpressure on both sides
        rmode = 2;
        for (int p = 0; p < 1000; p++) begin
            int len, dat;
            len = int'($urandom_range(12, 1));
            dat = ($urandom_range(9, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            send_pkt(len, dat, 1, 1);
        end
        rmode = 1;
        wait_drain();

        // reset mid-TLP with two committed TLPs stored
        rmode = 0;
        step(2);
        send_pkt(3, -1, 1, 0);
        send_pkt(3, -1, 1, 0);
        send_pkt(2, -1, 0, 0);
        user_reset = 1'b1;
        step(2);
        user_reset = 1'b0;
        step(1);
        chk("post_rst_tvalid", cw_t'(m_if.tvalid), cw_t'(0));
        chk("post_rst_pkt_count", cw_t'(pkt_count), cw_t'(0));
        rmode = 1;
        step(3);
        chk("post_rst_idle", cw_t'(m_if.tvalid), cw_t'(0));
        rise_edge = -1;
        send_pkt(3, -1, 1, 0);
        check_latency("latency_after_reset");
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
